// File: rtl/param_tx_pkg.sv
// Shared types and constants for the parameter TX sequencer: FSM states,
// RAM map, status-word layout and the word-count clamp.
package param_tx_pkg;

    localparam int          ADDR_W        = 11;
    localparam int          PAYLOAD_WORDS = 1024;
    localparam logic [10:0] STATUS_ADDR   = 11'd1024;
    localparam int          BUF_DEPTH     = 2;
    localparam int          RD_LAT        = 2;
    localparam logic [3:0]  BYTE_EN       = 4'hF;

    localparam int ST_FLAG_BIT  = 31;
    localparam int ST_ABORT_BIT = 30;
    localparam int ST_CNT_LSB   = 16;
    localparam int ST_CNT_MSB   = 26;
    localparam int ST_SEQ_MSB   = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_STATUS,
        S_DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] c);
        return (c > ADDR_W'(PAYLOAD_WORDS)) ? ADDR_W'(PAYLOAD_WORDS) : c;
    endfunction

    function automatic logic [31:0] status_word(input logic aborted,
                                                input logic [ADDR_W-1:0] cnt,
                                                input logic [15:0] seq);
        logic [31:0] w;
        w                         = '0;
        w[ST_FLAG_BIT]            = 1'b1;
        w[ST_ABORT_BIT]           = aborted;
        w[ST_CNT_MSB:ST_CNT_LSB]  = cnt;
        w[ST_SEQ_MSB:0]           = seq;
        return w;
    endfunction

endpackage

// File: rtl/param_tx_sequencer_skid.sv
// Small circular FIFO between the RAM read pipeline and the tx stream;
// flush empties it in one cycle without touching stored data.
module param_tx_skid #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PW-1:0]           r_wr, r_rd;
    logic [CW-1:0]           r_cnt;
    logic                    w_do_push, w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_cnt != '0);
    assign w_do_push = i_push && ((r_cnt != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_do_pop)
                r_rd <= ptr_inc(r_rd);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/param_tx_sequencer.sv
// Streams a block of the parameter TX RAM out over valid/ready and writes a
// completion status word. Optional trailing checksum beat: PARAM_TX_CHECKSUM_EN.
module param_tx_sequencer
    import param_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] base_addr,
    input  logic [10:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [10:0] ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    // FIFO holds the reads still travelling through the RAM pipeline on top of
    // BUF_DEPTH skid entries, so back-to-back reads sustain one word per cycle.
    localparam int FIFO_DEPTH = BUF_DEPTH + RD_LAT;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int CRW        = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    state_t          r_state, w_next;
    logic [9:0]      r_rd_addr;
    logic [10:0]     r_rd_left, r_count, r_sent, w_sent_nxt, w_cnt_clamped;
    logic [15:0]     r_seq;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [10:0]     r_ram_addr;
    logic            r_ram_cs, r_ram_we;
    logic [31:0]     r_ram_wdata;
    logic            w_start_acc, w_abort_acc, w_issue, w_pop, w_pay_pop;
    logic            w_push, w_flush, w_fifo_valid, w_empty_after, w_drained;
    logic [31:0]     w_push_data, w_fifo_data;
    logic [CW-1:0]   w_occ;
    logic [CRW-1:0]  w_used, w_cap;
    logic            w_busy, w_done;
    logic            w_unused;

    assign w_unused      = base_addr[10];
    assign w_cnt_clamped = clamp_count(word_count);
    assign w_start_acc   = start && (r_state == S_IDLE);
    assign w_abort_acc   = abort && ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_flush       = w_abort_acc;
    assign w_pop         = w_fifo_valid && tx_ready;
    assign w_pay_pop     = w_pop && (r_sent != r_count);
    assign w_sent_nxt    = r_sent + 11'(w_pay_pop);

    assign w_used  = CRW'(w_occ) + CRW'($countones(r_vld_pipe));
    assign w_cap   = CRW'(FIFO_DEPTH) + CRW'(w_pop);
    assign w_issue = (r_state == S_READ) && (r_rd_left != '0) && !w_abort_acc && (w_used < w_cap);
    assign w_empty_after = (r_vld_pipe == '0) && ((w_occ == '0) || ((w_occ == CW'(1)) && w_pop));

`ifdef PARAM_TX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
    logic [31:0] r_sum;
    logic        r_ck_pushed, w_ck_push;

    // Checksum enters the FIFO once every payload read has landed.
    assign w_ck_push   = (r_state == S_DRAIN) && !r_ck_pushed && (r_vld_pipe == '0) &&
                         (w_occ != CW'(FIFO_DEPTH)) && !w_abort_acc;
    assign w_push      = (r_vld_pipe[RD_LAT-1] || w_ck_push) && !w_flush;
    assign w_push_data = w_ck_push ? r_sum : ram_readdata;
    assign w_drained   = r_ck_pushed && w_empty_after;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum       <= '0;
            r_ck_pushed <= 1'b0;
        end else if (w_start_acc) begin
            r_sum       <= '0;
            r_ck_pushed <= 1'b0;
        end else begin
            if (r_vld_pipe[RD_LAT-1])
                r_sum <= r_sum + ram_readdata;
            if (w_ck_push)
                r_ck_pushed <= 1'b1;
        end
    end
`else
    localparam bit CK_EN = 1'b0;
    assign w_push      = r_vld_pipe[RD_LAT-1] && !w_flush;
    assign w_push_data = ram_readdata;
    assign w_drained   = w_empty_after;
`endif

    param_tx_skid #(.DEPTH(FIFO_DEPTH), .W(32)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_occ)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start)
                          w_next = ((w_cnt_clamped == '0) && !CK_EN) ? S_STATUS : S_READ;
            S_READ:   if (w_abort_acc)            w_next = S_STATUS;
                      else if (r_rd_left == '0)   w_next = S_DRAIN;
            S_DRAIN:  if (w_abort_acc || w_drained) w_next = S_STATUS;
            S_STATUS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_READ) || (r_state == S_DRAIN) || (r_state == S_STATUS);
        w_done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr   <= '0;
            r_rd_left   <= '0;
            r_count     <= '0;
            r_sent      <= '0;
            r_seq       <= '0;
            r_vld_pipe  <= '0;
            r_ram_addr  <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_vld_pipe <= w_abort_acc ? '0 : {r_vld_pipe[RD_LAT-2:0], w_issue};
            r_sent     <= (r_state == S_DONE) ? '0 : w_sent_nxt;
            if (w_start_acc) begin
                r_rd_addr <= base_addr[9:0];
                r_count   <= w_cnt_clamped;
                r_rd_left <= w_cnt_clamped;
            end
            // 10-bit read pointer wraps 1023 -> 0 and can never reach STATUS_ADDR.
            if (w_issue) begin
                r_ram_cs   <= 1'b1;
                r_ram_addr <= {1'b0, r_rd_addr};
                r_rd_addr  <= r_rd_addr + 10'd1;
                r_rd_left  <= r_rd_left - 11'd1;
            end
            if ((w_next == S_STATUS) && (r_state != S_STATUS)) begin
                r_ram_cs    <= 1'b1;
                r_ram_we    <= 1'b1;
                r_ram_addr  <= STATUS_ADDR;
                r_ram_wdata <= status_word(w_abort_acc, w_sent_nxt, r_seq);
            end
            if (r_state == S_STATUS)
                r_seq <= r_seq + 16'd1;
        end
    end

    assign busy           = w_busy;
    assign done           = w_done;
    assign ram_address    = r_ram_addr;
    assign ram_chipselect = r_ram_cs;
    assign ram_write      = r_ram_we;
    assign ram_byteenable = BYTE_EN;
    assign ram_writedata  = r_ram_wdata;
    assign tx_data        = w_fifo_data;
    assign tx_valid       = w_fifo_valid;

endmodule

// File: tb/tb_param_tx_sequencer.sv
// Scoreboard bench for param_tx_sequencer: stimulus pushes expected beats and
// status words from a word-level model; a negedge monitor pops and compares.
module tb_param_tx_sequencer;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
    logic [10:0] base_addr = '0, word_count = '0;
    logic        busy, done, ram_chipselect, ram_write, tx_valid;
    logic [10:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata, ram_readdata, tx_data;

    always #5 clk = ~clk;

    param_tx_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // RAM port 2: address registered on the edge, read data unregistered.
    logic [31:0] mem [0:1024];
    logic [31:0] ref_mem [0:1023];
    logic [10:0] rq = '0;
    always @(posedge clk)
        if (ram_chipselect) begin
            if (ram_write) mem[ram_address] <= ram_writedata;
            else           rq <= ram_address;
        end
    assign ram_readdata = mem[rq];

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$], exp_st[$];
    int          hs_cyc[$];
    int          beats = 0, done_cnt = 0, wr_cyc = -1, first_vld = -1, acc_cyc = 0;
    int          seq_m = 0;
    int          pat[6] = '{1, 0, 0, 1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor
    initial begin
        logic        prev_stall, prev_abort;
        logic [31:0] prev_data;
        prev_stall = 1'b0; prev_abort = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (tx_valid && first_vld < 0) first_vld = cyc;
                if (prev_stall && !prev_abort) begin
                    chk("hold_valid", tx_valid, 1);
                    chk("hold_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_beat");
                    else chk("beat_data", tx_data, exp_q.pop_front());
                    beats++;
                    hs_cyc.push_back(cyc);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_abort = abort;
                if (ram_chipselect && ram_write) begin
                    chk("status_addr", 32'(ram_address), 32'd1024);
                    chk("status_be", 32'(ram_byteenable), 32'hF);
                    if (exp_st.size() == 0) fail_now("unexpected_status_write");
                    else chk("status_word", ram_writedata, exp_st.pop_front());
                    wr_cyc = cyc;
                end
                if (ram_chipselect && !ram_write)
                    chk("read_addr_in_payload", 32'(ram_address < 11'd1024), 32'd1);
                if (done) begin
                    done_cnt++;
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    function automatic int clampc(input int c);
        return (c > 1024) ? 1024 : c;
    endfunction

    task automatic expect_beats(input int base, input int cnt);
        for (int i = 0; i < clampc(cnt); i++) exp_q.push_back(ref_mem[(base + i) % 1024]);
    endtask

    task automatic expect_status(input int ab, input int cnt);
        exp_st.push_back(32'h8000_0000 | (32'(ab) << 30) | (32'(clampc(cnt)) << 16) | 32'(seq_m));
        seq_m = (seq_m + 1) % 65536;
    endtask

    task automatic do_start(input int base, input int cnt, input logic with_abort);
        @(posedge clk); #1;
        base_addr = 11'(base); word_count = 11'(cnt);
        start = 1'b1; abort = with_abort;
        acc_cyc = cyc + 1; first_vld = -1; beats = 0; hs_cyc.delete();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int mode);
        int d0, k, p;
        d0 = done_cnt; k = 0;
        while (done_cnt == d0 && k < budget) begin
            p = cyc - acc_cyc - 3;
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = (p >= 0 && p < 6) ? pat[p][0] : 1'b1;
            endcase
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == d0) fail_now("timeout_waiting_done");
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("status_left", 32'(exp_st.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_ram_cs"}, 32'(ram_chipselect), 0);
        chk({tag, "_ram_we"}, 32'(ram_write), 0);
        chk({tag, "_ram_addr"}, 32'(ram_address), 0);
        chk({tag, "_ram_wdata"}, ram_writedata, 0);
        chk({tag, "_ram_be"}, 32'(ram_byteenable), 32'hF);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            if (i < 4) ref_mem[i] = 32'hA0 + 32'(i);
            mem[i] = ref_mem[i];
        end
        mem[1024] = '0;

        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        reset_n = 1'b1;

        // Basic block, full-rate stream, latency and status format
        tx_ready = 1'b1;
        expect_beats(0, 4); expect_status(0, 4);
        do_start(0, 4, 1'b0);
        wait_done(50, 0);
        chk("first_valid_latency", 32'(first_vld - acc_cyc), 32'd3);
        chk("t1_beat_count", 32'(hs_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_cyc.size(); i++)
            chk("t1_beat_cycle", 32'(hs_cyc[i]), 32'(acc_cyc + 3 + i));
        chk("t1_status_ram", mem[1024], 32'h8004_0000);

        // Backpressure pattern, second transfer
        expect_beats(100, 3); expect_status(0, 3);
        do_start(100, 3, 1'b0);
        wait_done(50, 2);
        chk("t2_status_ram", mem[1024], 32'h8003_0001);

        // Address wrap past the end of the payload region
        expect_beats(1022, 4); expect_status(0, 4);
        do_start(1022, 4, 1'b0);
        wait_done(50, 0);

        // Abort after two beats
        tx_ready = 1'b1;
        expect_beats(200, 10);
        do_start(200, 10, 1'b0);
        k = 0;
        while (beats < 2 && k < 40) begin @(posedge clk); #1; k++; end
        if (beats < 2) fail_now("timeout_abort_beats");
        tx_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        expect_status(1, 2);
        @(negedge clk);
        chk("abort_valid_drop", 32'(tx_valid), 0);
        wait_done(20, 0);
        chk("abort_status_hi", 32'(mem[1024][31:16]), 32'hC002);

        // Abort coinciding with the final handshake
        tx_ready = 1'b0;
        expect_beats(300, 1);
        do_start(300, 1, 1'b0);
        k = 0;
        while (!tx_valid && k < 20) begin @(posedge clk); #1; k++; end
        if (!tx_valid) fail_now("timeout_final_valid");
        tx_ready = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        expect_status(1, 1);
        wait_done(20, 0);

        // Zero count, with a start while busy that must be ignored
        tx_ready = 1'b1;
        expect_status(0, 0);
        do_start(5, 0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20, 0);
        chk("zero_status_latency", 32'((wr_cyc - acc_cyc) <= 2), 32'd1);
        chk("zero_no_valid", 32'(first_vld == -1), 32'd1);

        // Start together with abort in IDLE: start wins
        expect_beats(400, 6); expect_status(0, 6);
        do_start(400, 6, 1'b1);
        wait_done(60, 1);

        // Randomized blocks under random backpressure
        for (int t = 0; t < 5; t++) begin
            int b, c;
            b = $urandom_range(0, 1023);
            c = $urandom_range(1, 40);
            expect_beats(b, c); expect_status(0, c);
            do_start(b, c, 1'b0);
            wait_done(400, 1);
        end

        // Oversized count clamps to the full payload
        expect_beats(17, 2000); expect_status(0, 2000);
        do_start(17, 2000, 1'b0);
        wait_done(1500, 0);
        chk("clamp_count_field", 32'(mem[1024][26:16]), 32'd1024);

        // Asynchronous reset in the middle of READ
        tx_ready = 1'b1;
        do_start(50, 20, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        seq_m = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        expect_beats(0, 4); expect_status(0, 4);
        do_start(0, 4, 1'b0);
        wait_done(50, 0);
        chk("post_reset_status", mem[1024], 32'h8004_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
